// File: rtl/ddd_rat_seq.sv
// Delay-chip programming sequencer: shadows VME settings, applies them on a start
// trigger, handshakes with the programmer and retries or halts on verify failure.
module ddd_rat_seq (
  input  logic        clock,
  input  logic        global_reset,
  input  logic        wr_en,
  input  logic [19:0] wr_data,
  input  logic        cmd_go,
  input  logic        auto_en,
  input  logic [2:0]  retry_max,
  input  logic        ddd_busy,
  input  logic        ddd_verify_ok,
  output logic        ddd_start,
  output logic [3:0]  oe,
  output logic [3:0]  delay_ch0,
  output logic [3:0]  delay_ch1,
  output logic [3:0]  delay_ch2,
  output logic [3:0]  delay_ch3,
  output logic        done,
  output logic        fail,
  output logic        timeout,
  output logic [2:0]  retry_cnt,
  output logic        pending
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] REQ    = 3'd1;
  localparam logic [2:0] RUN    = 3'd2;
  localparam logic [2:0] SETTLE = 3'd3;
  localparam logic [2:0] CHECK  = 3'd4;
  localparam logic [2:0] HALT   = 3'd5;

  localparam logic [9:0] WDOG_MAX  = 10'd1023;
  localparam logic [2:0] RETRY_SAT = 3'd7;

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic [19:0] shadow;
  logic [19:0] load_data;
  logic [9:0]  wdog;
  logic        settle_cnt;
  logic        trigger;
  logic        wdog_expired;
  logic        in_handshake;
  logic        retry_ok;

  assign trigger      = cmd_go | (auto_en & pending);
  // A write coinciding with the trigger must be the one that gets applied.
  assign load_data    = wr_en ? wr_data : shadow;
  assign wdog_expired = (wdog == WDOG_MAX);
  assign in_handshake = (state == REQ) || (state == RUN);
  assign retry_ok     = (retry_cnt < retry_max);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (trigger) state_nxt = REQ;
      REQ: begin
        if (wdog_expired)  state_nxt = HALT;
        else if (ddd_busy) state_nxt = RUN;
      end
      RUN: begin
        if (wdog_expired)   state_nxt = HALT;
        else if (!ddd_busy) state_nxt = SETTLE;
      end
      SETTLE:  if (settle_cnt) state_nxt = CHECK;
      CHECK: begin
        if (ddd_verify_ok) state_nxt = IDLE;
        else if (retry_ok) state_nxt = REQ;
        else               state_nxt = HALT;
      end
      HALT:    if (cmd_go) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (global_reset) begin
      state      <= IDLE;
      ddd_start  <= 1'b0;
      settle_cnt <= 1'b0;
    end else begin
      state      <= state_nxt;
      ddd_start  <= (state_nxt == REQ);
      settle_cnt <= (state == SETTLE) ? ~settle_cnt : 1'b0;
    end
  end

  // The pending clear on a trigger is placed after the write so it wins.
  always_ff @(posedge clock) begin
    if (global_reset) begin
      shadow    <= 20'd0;
      pending   <= 1'b0;
      oe        <= 4'd0;
      delay_ch3 <= 4'd0;
      delay_ch2 <= 4'd0;
      delay_ch1 <= 4'd0;
      delay_ch0 <= 4'd0;
    end else begin
      if (wr_en) begin
        shadow  <= wr_data;
        pending <= 1'b1;
      end
      if (state == IDLE && trigger) begin
        oe        <= load_data[19:16];
        delay_ch3 <= load_data[15:12];
        delay_ch2 <= load_data[11:8];
        delay_ch1 <= load_data[7:4];
        delay_ch0 <= load_data[3:0];
        pending   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (global_reset) begin
      wdog <= 10'd0;
    end else if (state == IDLE && trigger) begin
      wdog <= 10'd0;
    end else if (state == CHECK && !ddd_verify_ok && retry_ok) begin
      wdog <= 10'd0;
    end else if (in_handshake && !wdog_expired) begin
      if (state == REQ && ddd_busy) wdog <= 10'd0;
      else                          wdog <= wdog + 10'd1;
    end
  end

  // done and fail are set on exclusive paths and both cleared at sequence start.
  always_ff @(posedge clock) begin
    if (global_reset) begin
      done      <= 1'b0;
      fail      <= 1'b0;
      timeout   <= 1'b0;
      retry_cnt <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (trigger) begin
            done      <= 1'b0;
            fail      <= 1'b0;
            timeout   <= 1'b0;
            retry_cnt <= 3'd0;
          end
        end
        REQ, RUN: begin
          if (wdog_expired) begin
            timeout <= 1'b1;
            fail    <= 1'b1;
            done    <= 1'b0;
          end
        end
        CHECK: begin
          if (ddd_verify_ok) begin
            done <= 1'b1;
            fail <= 1'b0;
          end else if (retry_ok) begin
            if (retry_cnt != RETRY_SAT) retry_cnt <= retry_cnt + 3'd1;
          end else begin
            fail <= 1'b1;
            done <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ddd_rat_seq.sv
// Directed bench for ddd_rat_seq with a small behavioural model of the
// delay-chip programmer answering the start/busy/verify handshake.
module tb_ddd_rat_seq;

  logic        clock = 1'b0;
  logic        global_reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [19:0] wr_data = 20'd0;
  logic        cmd_go = 1'b0;
  logic        auto_en = 1'b0;
  logic [2:0]  retry_max = 3'd0;
  logic        ddd_busy = 1'b0;
  logic        ddd_verify_ok = 1'b0;
  logic        ddd_start;
  logic [3:0]  oe, delay_ch0, delay_ch1, delay_ch2, delay_ch3;
  logic        done, fail, timeout, pending;
  logic [2:0]  retry_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // programmer model controls
  logic [3:0] verify_pattern = 4'b1111;
  int         pattern_gen = 0;
  logic       model_stuck = 1'b0;

  // model internals
  int seen_gen = 0;
  int vidx = 0;
  int hi_cnt = 0;
  int busy_cnt = 0;
  int phase = 0;

  // start monitor counters (monotonic, snapshot by main sequence)
  int   start_hi_total = 0;
  int   pulse_total = 0;
  logic start_prev = 1'b0;

  int hi_snap, pulse_snap;

  ddd_rat_seq dut (
    .clock(clock), .global_reset(global_reset), .wr_en(wr_en), .wr_data(wr_data),
    .cmd_go(cmd_go), .auto_en(auto_en), .retry_max(retry_max),
    .ddd_busy(ddd_busy), .ddd_verify_ok(ddd_verify_ok), .ddd_start(ddd_start),
    .oe(oe), .delay_ch0(delay_ch0), .delay_ch1(delay_ch1), .delay_ch2(delay_ch2),
    .delay_ch3(delay_ch3), .done(done), .fail(fail), .timeout(timeout),
    .retry_cnt(retry_cnt), .pending(pending)
  );

  always #5 clock = ~clock;

  // Programmer: busy rises after start has been high 3 cycles, falls 90 cycles
  // later together with the next verify result from the pattern.
  always @(negedge clock) begin
    if (pattern_gen != seen_gen) begin
      seen_gen = pattern_gen;
      vidx = 0;
    end
    if (phase == 0) begin
      if (ddd_start && !model_stuck) begin
        hi_cnt++;
        if (hi_cnt == 3) begin
          ddd_busy = 1'b1;
          busy_cnt = 0;
          hi_cnt = 0;
          phase = 1;
        end
      end else begin
        hi_cnt = 0;
      end
    end else begin
      busy_cnt++;
      if (busy_cnt == 90) begin
        ddd_busy = 1'b0;
        ddd_verify_ok = verify_pattern[vidx];
        if (vidx < 3) vidx++;
        phase = 0;
      end
    end
  end

  always @(posedge clock) begin
    if (ddd_start) start_hi_total++;
    if (ddd_start && !start_prev) pulse_total++;
    start_prev = ddd_start;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic [19:0] data, input logic go);
    wr_en   = wr;
    wr_data = data;
    cmd_go  = go;
    @(negedge clock);
    wr_en  = 1'b0;
    cmd_go = 1'b0;
  endtask

  task automatic resetDut();
    global_reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    global_reset = 1'b0;
  endtask

  task automatic setPattern(input logic [3:0] p);
    verify_pattern = p;
    pattern_gen++;
  endtask

  task automatic snapStart();
    hi_snap    = start_hi_total;
    pulse_snap = pulse_total;
  endtask

  function automatic bit flagOf(input int sel);
    case (sel)
      0:       return done;
      1:       return fail;
      2:       return timeout;
      3:       return (oe == 4'hA);
      default: return 1'b0;
    endcase
  endfunction

  task automatic waitFlag(input int sel, input int limit, input string tag);
    int n = 0;
    bit hit = 1'b0;
    while (!hit && n < limit) begin
      @(negedge clock);
      n++;
      hit = flagOf(sel);
    end
    if (!hit) checkOutput(tag, 32'd0, 32'd1);
  endtask

  initial begin
    @(negedge clock);
    setPattern(4'b1111);
    resetDut();

    // reset state
    checkOutput("rst_start", ddd_start, 0);
    checkOutput("rst_applied", {oe, delay_ch3, delay_ch2, delay_ch1, delay_ch0}, 0);
    checkOutput("rst_flags", {done, fail, timeout, pending}, 0);
    checkOutput("rst_retry", retry_cnt, 0);

    // basic program sequence
    applyStimulus(1'b1, 20'hF4321, 1'b0);
    checkOutput("wr_pending", pending, 1);
    checkOutput("wr_not_applied", oe, 0);
    snapStart();
    applyStimulus(1'b0, 20'd0, 1'b1);
    checkOutput("go_applied", {oe, delay_ch3, delay_ch2, delay_ch1, delay_ch0}, 20'hF4321);
    checkOutput("go_start", ddd_start, 1);
    checkOutput("go_pending", pending, 0);
    waitFlag(0, 300, "basic_wait_done");
    checkOutput("basic_done_fail", {done, fail}, 2'b10);
    checkOutput("basic_retry", retry_cnt, 0);
    checkOutput("basic_start_cycles", start_hi_total - hi_snap, 3);
    checkOutput("basic_pulses", pulse_total - pulse_snap, 1);
    checkOutput("basic_pending", pending, 0);

    // two retries then success
    setPattern(4'b1100);
    resetDut();
    retry_max = 3'd2;
    applyStimulus(1'b1, 20'h1ABCD, 1'b0);
    snapStart();
    applyStimulus(1'b0, 20'd0, 1'b1);
    waitFlag(0, 600, "retry_wait_done");
    checkOutput("retry_pulses", pulse_total - pulse_snap, 3);
    checkOutput("retry_cnt", retry_cnt, 2);
    checkOutput("retry_done_fail", {done, fail}, 2'b10);
    checkOutput("retry_applied", {oe, delay_ch3, delay_ch2, delay_ch1, delay_ch0}, 20'h1ABCD);

    // retries exhausted -> HALT
    setPattern(4'b0000);
    resetDut();
    retry_max = 3'd1;
    applyStimulus(1'b1, 20'h25555, 1'b0);
    snapStart();
    applyStimulus(1'b0, 20'd0, 1'b1);
    waitFlag(1, 600, "halt_wait_fail");
    checkOutput("halt_pulses", pulse_total - pulse_snap, 2);
    checkOutput("halt_retry", retry_cnt, 1);
    checkOutput("halt_done_fail", {done, fail}, 2'b01);
    auto_en = 1'b1;
    snapStart();
    applyStimulus(1'b1, 20'h6789A, 1'b0);
    repeat (20) @(negedge clock);
    checkOutput("halt_no_auto", start_hi_total - hi_snap, 0);
    checkOutput("halt_pending", pending, 1);
    auto_en = 1'b0;
    applyStimulus(1'b0, 20'd0, 1'b1);
    checkOutput("halt_exit_start", ddd_start, 0);
    checkOutput("halt_exit_fail_kept", fail, 1);
    setPattern(4'b1111);
    applyStimulus(1'b0, 20'd0, 1'b1);
    checkOutput("restart_start", ddd_start, 1);
    checkOutput("restart_flags", {done, fail}, 0);
    checkOutput("restart_applied", {oe, delay_ch0}, 8'h6A);
    waitFlag(0, 300, "restart_wait_done");

    // retry_max = 0 fails at first verify
    setPattern(4'b0000);
    resetDut();
    retry_max = 3'd0;
    snapStart();
    applyStimulus(1'b0, 20'd0, 1'b1);
    waitFlag(1, 300, "nore_wait_fail");
    checkOutput("nore_pulses", pulse_total - pulse_snap, 1);
    checkOutput("nore_retry", retry_cnt, 0);

    // write coinciding with trigger
    setPattern(4'b1111);
    resetDut();
    applyStimulus(1'b1, 20'hF4321, 1'b0);
    applyStimulus(1'b1, 20'h12345, 1'b1);
    checkOutput("same_cycle_applied", {oe, delay_ch3, delay_ch2, delay_ch1, delay_ch0}, 20'h12345);
    checkOutput("same_cycle_pending", pending, 0);
    waitFlag(0, 300, "same_cycle_wait_done");

    // watchdog
    model_stuck = 1'b1;
    resetDut();
    snapStart();
    applyStimulus(1'b0, 20'd0, 1'b1);
    waitFlag(2, 1200, "wdog_wait_timeout");
    checkOutput("wdog_flags", {done, fail, timeout}, 3'b011);
    checkOutput("wdog_start", ddd_start, 0);
    checkOutput("wdog_length", (start_hi_total - hi_snap >= 1023) && (start_hi_total - hi_snap <= 1025), 1);
    model_stuck = 1'b0;

    // write during RUN with auto start
    setPattern(4'b1111);
    resetDut();
    applyStimulus(1'b1, 20'h31234, 1'b0);
    applyStimulus(1'b0, 20'd0, 1'b1);
    repeat (10) @(negedge clock);
    auto_en = 1'b1;
    applyStimulus(1'b1, 20'hA5555, 1'b0);
    checkOutput("run_wr_pending", pending, 1);
    checkOutput("run_wr_held", oe, 4'h3);
    waitFlag(0, 300, "auto_wait_done1");
    checkOutput("auto_held_at_done", {oe, delay_ch3, delay_ch2, delay_ch1, delay_ch0}, 20'h31234);
    checkOutput("auto_pending_at_done", pending, 1);
    waitFlag(3, 5, "auto_wait_apply");
    checkOutput("auto_applied", {delay_ch3, delay_ch2, delay_ch1, delay_ch0}, 16'h5555);
    checkOutput("auto_pending_clr", pending, 0);
    checkOutput("auto_start", ddd_start, 1);
    waitFlag(0, 300, "auto_wait_done2");
    snapStart();
    repeat (20) @(negedge clock);
    checkOutput("auto_no_rerun", start_hi_total - hi_snap, 0);
    auto_en = 1'b0;

    // reset during RUN with a pending write
    resetDut();
    applyStimulus(1'b1, 20'h77777, 1'b1);
    repeat (10) @(negedge clock);
    applyStimulus(1'b1, 20'hB1111, 1'b0);
    auto_en = 1'b1;
    global_reset = 1'b1;
    @(negedge clock);
    global_reset = 1'b0;
    checkOutput("midrst_start", ddd_start, 0);
    checkOutput("midrst_applied", {oe, delay_ch3, delay_ch2, delay_ch1, delay_ch0}, 0);
    checkOutput("midrst_flags", {done, fail, timeout, pending}, 0);
    snapStart();
    repeat (150) @(negedge clock);
    checkOutput("midrst_no_restart", start_hi_total - hi_snap, 0);
    auto_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ddd_rat_seq.md
DDD_RAT_SEQ -- requirements
Module: ddd_rat_seq

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clock and global_reset.
REQ-002 clock  in  1  same clock that drives the downstream delay-chip programmer.
REQ-003 global_reset  in  1  synchronous active-high reset.
REQ-004 wr_en  in  1  one-cycle VME write strobe for new settings.
REQ-005 wr_data  in  20  {oe[3:0], ch3[3:0], ch2[3:0], ch1[3:0], ch0[3:0]}, with oe in the MSBs.
REQ-006 cmd_go  in  1  one-cycle request to program the chip.
REQ-007 auto_en  in  1  when 1, pending settings are programmed without cmd_go.
REQ-008 retry_max  in  3  maximum number of retries after a verify failure.
REQ-009 ddd_busy, ddd_verify_ok  in  1 each  busy and verify result returned by the programmer.
REQ-010 ddd_start  out  1  start level sent to the programmer.
REQ-011 oe, delay_ch0..delay_ch3  out  4 each  applied settings, stable while a sequence runs.
REQ-012 done, fail, timeout  out  1 each  sticky status flags.
REQ-013 retry_cnt  out  3  retries used in the current sequence.
REQ-014 pending  out  1  set when written settings have not yet been applied.

Function
REQ-015 Every write (wr_en=1) SHALL load wr_data into a 20-bit shadow register and set pending, in any state.
REQ-016 The FSM states SHALL be IDLE, REQ, RUN, SETTLE, CHECK and HALT.
REQ-017 IDLE SHALL go to REQ on cmd_go=1, or on auto_en=1 with pending=1.
  - On that transition, copy shadow to the applied outputs.
  - Clear pending, done, fail, timeout and retry_cnt.
REQ-018 If wr_en and the IDLE->REQ trigger occur in the same cycle, the new wr_data SHALL be applied and pending SHALL end 0.
REQ-019 Applied outputs SHALL change only on the IDLE->REQ transition.
  - They never change in REQ, RUN, SETTLE or CHECK.
  - A write during a sequence only updates shadow and sets pending.
REQ-020 REQ SHALL drive ddd_start=1 and go to RUN on the first cycle ddd_busy=1.
REQ-021 RUN SHALL drive ddd_start=0 and go to SETTLE on the first cycle ddd_busy=0.
REQ-022 SETTLE SHALL last exactly 2 cycles, then go to CHECK, so that verify_ok is stable.
REQ-023 CHECK SHALL take one of three paths:
  - ddd_verify_ok=1: set done, go to IDLE.
  - ddd_verify_ok=0 and retry_cnt<retry_max: increment retry_cnt, go to REQ with the same applied settings.
  - Otherwise: set fail, go to HALT.
REQ-024 ddd_start SHALL be registered and equal 1 only in REQ.
REQ-025 A 10-bit watchdog SHALL behave as follows:
  - It clears on every entry to REQ and on every REQ->RUN transition.
  - It counts each cycle in REQ or RUN.
  - At count 1023 it sets timeout and fail, drives ddd_start=0 and goes to HALT.
REQ-026 HALT SHALL hold ddd_start=0 and keep the flags.
  - It returns to IDLE on cmd_go=1, which then behaves as the IDLE trigger on the following cycle.
  - Auto-start never leaves HALT.
REQ-027 retry_max=0 SHALL mean no retries: the first failure goes to HALT with retry_cnt=0.
REQ-028 retry_cnt SHALL saturate at 7 and never wrap.
REQ-029 cmd_go SHALL be ignored in REQ, RUN, SETTLE and CHECK.
REQ-030 done and fail SHALL never be 1 at the same time.

Reset
REQ-031 global_reset=1 SHALL, on the next clock edge:
  - put the FSM in IDLE;
  - set ddd_start=0, shadow=0, all applied outputs=0;
  - clear pending, done, fail, timeout, retry_cnt and the watchdog.
REQ-032 Reset in the middle of a sequence SHALL drop ddd_start within one cycle, and SHALL NOT auto-restart until a new write sets pending.

Verification
REQ-033 Write 20'hF4321, then cmd_go; the model raises busy 3 cycles after start and drops it 90 cycles later with verify_ok=1.
  - Expect oe=F, ch3=4, ch2=3, ch1=2, ch0=1.
  - Expect ddd_start high 3 cycles, done=1, retry_cnt=0, pending=0.
REQ-034 retry_max=2; the model returns verify_ok=0, 0, 1.
  - Expect three ddd_start pulses, retry_cnt=2, done=1, fail=0.
REQ-035 retry_max=1; verify_ok is always 0.
  - Expect two pulses, then fail=1, HALT, retry_cnt=1.
  - cmd_go returns the block to IDLE.
REQ-036 ddd_busy is held at 0 after cmd_go.
  - Expect timeout=1 and fail=1 after 1023 cycles in REQ, and ddd_start=0.
REQ-037 auto_en=1; write 20'hA5555 during RUN.
  - Expect the applied outputs unchanged until done.
  - Expect pending=1, then an automatic new sequence applying oe=A, all channels=5.
REQ-038 Assert global_reset during RUN.
  - Expect ddd_start=0, all outputs 0, state IDLE, and no restart with auto_en=1.
